cpu_sram_arb: RTL and testbench
===============================

CPU_SRAM_ARB -- requirements
Module: cpu_sram_arb

Interface
REQ-001 Parameter DATA_PRIO, default 1, SHALL select the master that wins simultaneous requests in IDLE: 1 = data master wins, 0 = inst master wins.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 inst_req  input  1  instruction master request.
REQ-005 inst_wr/inst_size/inst_wstrb/inst_addr/inst_wdata  input  1/2/4/32/32  instruction master write flag, access size, byte strobes, address, write data.
REQ-006 inst_addr_ok  output  1  request from the instruction master accepted.
REQ-007 inst_data_ok/inst_rdata  output  1/32  transaction complete, read data.
REQ-008 data_req, data_wr/data_size/data_wstrb/data_addr/data_wdata  input  1, 1/2/4/32/32  data master, same meaning as the inst_* inputs.
REQ-009 data_addr_ok, data_data_ok/data_rdata  output  1, 1/32  data master, same meaning as the inst_* outputs.
REQ-010 sram_req, sram_wr/sram_size/sram_wstrb/sram_addr/sram_wdata  output  1, 1/2/4/32/32  shared slave port request.
REQ-011 sram_addr_ok, sram_data_ok/sram_rdata  input  1, 1/32  slave request accepted, slave response with read data.

Function
REQ-012 The block SHALL share one SRAM-like slave port between two masters and keep exactly one transaction outstanding at a time.
REQ-013 The FSM SHALL have three states: IDLE, ADDR, DATA.
REQ-014 In IDLE, if any master request is high, the block SHALL select one master per DATA_PRIO and do the following in that cycle:
- pulse that master's addr_ok for one cycle;
- latch wr, size, wstrb, addr and wdata into holding registers;
- record the owner;
- go to ADDR on the next edge.
REQ-015 A master's addr_ok SHALL be high only in IDLE and only for the granted master; the other master's addr_ok SHALL stay 0.
REQ-016 In ADDR, sram_req SHALL be 1, and sram_wr/size/wstrb/addr/wdata SHALL come from the holding registers, stable until sram_addr_ok.
- ADDR -> DATA on the edge where sram_addr_ok is 1.
- Otherwise the block SHALL stay in ADDR.
REQ-017 In IDLE and DATA, sram_req SHALL be 0.
REQ-018 In DATA, when sram_data_ok is 1:
- the owner's data_ok SHALL be 1 in that same cycle, and its rdata SHALL equal sram_rdata (combinational forwarding);
- the FSM SHALL return to IDLE.
REQ-019 The non-owner's data_ok SHALL be 0 at all times outside its own transactions.
REQ-020 The rdata outputs SHALL be sram_rdata when the port's data_ok is 1, and 32'h0 otherwise.
REQ-021 sram_data_ok SHALL be ignored in IDLE and ADDR.
REQ-022 sram_addr_ok SHALL be ignored in IDLE and DATA.
REQ-023 Minimum transaction latency SHALL be:
- master addr_ok at cycle 0;
- sram_req from cycle 1;
- with sram_addr_ok at cycle 1 and sram_data_ok at cycle 2, master data_ok at cycle 2;
- the next grant possible at cycle 3.
REQ-024 A master request held high across its own completion SHALL be granted again in the next IDLE cycle and treated as a new transaction.
REQ-025 With DATA_PRIO=1, a continuously asserted data_req SHALL starve inst_req; the block SHALL NOT include fairness logic.
REQ-026 Holding registers SHALL load only on a grant, and SHALL ignore master input changes while in ADDR or DATA.
REQ-027 The block SHALL NOT alter size, wstrb or address alignment; it SHALL pass them through unchanged.

Reset
REQ-028 When resetn=0 at a rising edge:
- the FSM SHALL be in IDLE, owner SHALL be inst, and all holding registers SHALL be 0;
- during the reset cycle, sram_req, all addr_ok and all data_ok SHALL be 0.
REQ-029 A reset asserted in ADDR or DATA SHALL abandon the transaction with no data_ok pulse; any later sram_data_ok for it SHALL be ignored because the FSM is in IDLE.

Verification
REQ-030 Single read: data_req=1, data_addr=32'h1c00_0010 in IDLE -> data_addr_ok pulses; next cycle sram_req=1, sram_addr=32'h1c00_0010; sram_addr_ok then sram_data_ok with rdata=32'hDEAD_BEEF -> data_data_ok=1, data_rdata=32'hDEAD_BEEF, inst_data_ok=0.
REQ-031 Simultaneous requests, DATA_PRIO=1: both req high -> data granted first; inst_addr_ok pulses in the first IDLE cycle after data completes; sram_addr follows each owner.
REQ-032 Slave stall: sram_addr_ok held 0 for 5 cycles -> sram_req and sram_addr/wdata/wstrb stay stable for all 5 cycles, even if data_addr changes.
REQ-033 Store: data_wr=1, wstrb=4'b0011, wdata=32'h1234_5678 -> the same values appear on sram_*; data_data_ok pulses once on sram_data_ok.
REQ-034 Reset mid-DATA: resetn=0 for one cycle while waiting -> next cycle in IDLE; a stray sram_data_ok yields no master data_ok.
REQ-035 Back-to-back: inst_req held high with 1-cycle slave responses -> one inst_addr_ok every 3 cycles, no cycle with two addr_ok pulses.

Source files
------------

// File: rtl/cpu_sram_arb_if.sv
// SRAM-like request/response bus shared by CPU masters and the SRAM port.
// One outstanding transaction; addr_ok accepts a request, data_ok ends it.
interface cpu_sram_arb_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/cpu_sram_arb.sv
// Two-master arbiter onto one SRAM-like slave port.
// Fixed priority, one transaction in flight, request latched on grant.
module cpu_sram_arb #(
   parameter bit DATA_PRIO = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   cpu_sram_arb_if.slave  inst,
   cpu_sram_arb_if.slave  data,
   cpu_sram_arb_if.master sram
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   logic grant_data;
   logic grant_inst;

   assign grant_data = data.req & (DATA_PRIO | ~inst.req);
   assign grant_inst = inst.req & ~grant_data;

   // Next state, grant latching and all handshake outputs.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      wr_d       = wr_q;
      size_d     = size_q;
      wstrb_d    = wstrb_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;

      inst.addr_ok = 1'b0;
      data.addr_ok = 1'b0;
      inst.data_ok = 1'b0;
      data.data_ok = 1'b0;
      inst.rdata   = 32'h0;
      data.rdata   = 32'h0;

      sram.req   = 1'b0;
      sram.wr    = wr_q;
      sram.size  = size_q;
      sram.wstrb = wstrb_q;
      sram.addr  = addr_q;
      sram.wdata = wdata_q;

      unique case (state_q)
         IDLE: begin
            if (grant_data || grant_inst) begin
               inst.addr_ok = grant_inst;
               data.addr_ok = grant_data;
               owner_d = grant_data;
               wr_d    = grant_data ? data.wr    : inst.wr;
               size_d  = grant_data ? data.size  : inst.size;
               wstrb_d = grant_data ? data.wstrb : inst.wstrb;
               addr_d  = grant_data ? data.addr  : inst.addr;
               wdata_d = grant_data ? data.wdata : inst.wdata;
               state_d = ADDR;
            end
         end
         ADDR: begin
            sram.req = 1'b1;
            if (sram.addr_ok) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (sram.data_ok) begin
               if (owner_q) begin
                  data.data_ok = 1'b1;
                  data.rdata   = sram.rdata;
               end else begin
                  inst.data_ok = 1'b1;
                  inst.rdata   = sram.rdata;
               end
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Reset abandons any transaction and silences every handshake.
      if (!resetn) begin
         state_d      = IDLE;
         owner_d      = 1'b0;
         wr_d         = 1'b0;
         size_d       = 2'b0;
         wstrb_d      = 4'b0;
         addr_d       = 32'h0;
         wdata_d      = 32'h0;
         inst.addr_ok = 1'b0;
         data.addr_ok = 1'b0;
         inst.data_ok = 1'b0;
         data.data_ok = 1'b0;
         inst.rdata   = 32'h0;
         data.rdata   = 32'h0;
         sram.req     = 1'b0;
      end
   end

   // State, owner and holding registers.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

endmodule

// File: tb/tb_cpu_sram_arb.sv
// Directed bench for cpu_sram_arb with a slave model and a
// transaction scoreboard checked against every master response.
module tb_cpu_sram_arb;

   logic clk;
   logic resetn;

   cpu_sram_arb_if inst_if ();
   cpu_sram_arb_if data_if ();
   cpu_sram_arb_if sram_if ();

   cpu_sram_arb #(.DATA_PRIO(1'b1)) dut (
      .clk    (clk),
      .resetn (resetn),
      .inst   (inst_if),
      .data   (data_if),
      .sram   (sram_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_data;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   txn_t sb[$];
   int   gi_cyc[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc_n = 0;

   bit          sl_data = 0;
   bit          stray = 0;
   int          stall_left = 0;
   int          dok_cfg = 0;
   int          dok_wait = 0;
   logic [31:0] acc_addr = 32'h0;

   int g_inst = 0;
   int g_data = 0;
   int last_g = 0;
   bit seen_req = 0;
   int first_req_cyc = 0;
   int last_mdok = 0;
   int req_cnt = 0;
   int dok_cnt_d = 0;

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (a == 32'h1c00_0010) return 32'hDEAD_BEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic txn_t mk(input bit d, input logic wr,
                               input logic [1:0] sz, input logic [3:0] st,
                               input logic [31:0] a, input logic [31:0] wd);
      txn_t t;
      t.is_data = d;
      t.wr      = wr;
      t.size    = sz;
      t.wstrb   = st;
      t.addr    = a;
      t.wdata   = wd;
      t.rdata   = model_rd(a);
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit d, input logic rq, input txn_t t);
      if (d) begin
         data_if.req   = rq;
         data_if.wr    = t.wr;
         data_if.size  = t.size;
         data_if.wstrb = t.wstrb;
         data_if.addr  = t.addr;
         data_if.wdata = t.wdata;
      end else begin
         inst_if.req   = rq;
         inst_if.wr    = t.wr;
         inst_if.size  = t.size;
         inst_if.wstrb = t.wstrb;
         inst_if.addr  = t.addr;
         inst_if.wdata = t.wdata;
      end
   endtask

   // One clock: slave model responds, then all outputs are checked.
   task automatic cyc();
      logic        dok;
      logic        acc;
      logic        ei;
      logic        ed;
      logic [31:0] er;
      dok = 1'b0;
      acc = 1'b0;
      #1;
      sram_if.addr_ok = 1'b0;
      sram_if.data_ok = 1'b0;
      sram_if.rdata   = 32'h0;
      if (sl_data) begin
         if (dok_wait > 0) begin
            dok_wait--;
         end else begin
            dok = 1'b1;
            sram_if.data_ok = 1'b1;
            sram_if.rdata   = model_rd(acc_addr);
         end
      end else begin
         if (stray) begin
            sram_if.data_ok = 1'b1;
            sram_if.rdata   = 32'hBAD0_BAD0;
         end
         if (sram_if.req === 1'b1) begin
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               acc = 1'b1;
               sram_if.addr_ok = 1'b1;
            end
         end
      end
      #1;
      chk("dual_addr_ok", inst_if.addr_ok & data_if.addr_ok, 0);
      if (!resetn) begin
         chk("rst_outputs", {sram_if.req, inst_if.addr_ok,
             data_if.addr_ok, inst_if.data_ok, data_if.data_ok}, 0);
      end
      chk("addr_ok_busy", (inst_if.addr_ok | data_if.addr_ok) &
          (sl_data | sram_if.req), 0);
      if (inst_if.addr_ok || data_if.addr_ok) begin
         chk("grant_has_txn", sb.size() != 0, 1);
         if (sb.size() != 0) chk("grant_owner", data_if.addr_ok, sb[0].is_data);
         seen_req = 0;
         last_g = cyc_n;
         if (data_if.addr_ok) g_data++;
         if (inst_if.addr_ok) begin
            g_inst++;
            gi_cyc.push_back(cyc_n);
         end
      end
      if (sl_data) chk("req_in_data", sram_if.req, 0);
      if (sram_if.req) begin
         req_cnt++;
         if (!seen_req) begin
            seen_req = 1;
            first_req_cyc = cyc_n;
         end
         chk("req_has_txn", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            chk("sram_wr", sram_if.wr, sb[0].wr);
            chk("sram_size", sram_if.size, sb[0].size);
            chk("sram_wstrb", sram_if.wstrb, sb[0].wstrb);
            chk("sram_addr", sram_if.addr, sb[0].addr);
            chk("sram_wdata", sram_if.wdata, sb[0].wdata);
         end
      end
      if (acc) acc_addr = sram_if.addr;
      ei = dok && resetn && sb.size() != 0 && !sb[0].is_data;
      ed = dok && resetn && sb.size() != 0 && sb[0].is_data;
      er = (sb.size() != 0) ? sb[0].rdata : 32'h0;
      chk("inst_data_ok", inst_if.data_ok, ei);
      chk("data_data_ok", data_if.data_ok, ed);
      chk("inst_rdata", inst_if.rdata, ei ? er : 32'h0);
      chk("data_rdata", data_if.rdata, ed ? er : 32'h0);
      if (inst_if.data_ok || data_if.data_ok) last_mdok = cyc_n;
      if (data_if.data_ok) dok_cnt_d++;
      @(posedge clk);
      if (!resetn) begin
         sl_data = 0;
         sb.delete();
      end else begin
         if (acc) begin
            sl_data = 1;
            dok_wait = dok_cfg;
         end
         if (dok) begin
            sl_data = 0;
            if (sb.size() != 0) void'(sb.pop_front());
         end
      end
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic wait_grant(input bit d);
      int g0;
      g0 = d ? g_data : g_inst;
      for (int i = 0; i < 20; i++) begin
         if ((d ? g_data : g_inst) != g0) break;
         cyc();
      end
      chk(d ? "data_grant_seen" : "inst_grant_seen",
          (d ? g_data : g_inst) != g0, 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0 && !sl_data) break;
         cyc();
      end
      chk("txn_drained", sb.size() == 0 && !sl_data, 1);
   endtask

   initial begin
      txn_t t;
      txn_t z;
      int   g;
      int   g0;

      z = mk(0, 0, 2'd0, 4'h0, 32'h0, 32'h0);
      resetn = 1'b0;
      drive(0, 0, z);
      drive(1, 0, z);
      sram_if.addr_ok = 1'b0;
      sram_if.data_ok = 1'b0;
      sram_if.rdata   = 32'h0;

      // reset state
      @(negedge clk);
      data_if.req = 1'b1;
      inst_if.req = 1'b1;
      cyc();
      cyc();
      data_if.req = 1'b0;
      inst_if.req = 1'b0;
      chk("rst_sram_addr", sram_if.addr, 32'h0);
      chk("rst_sram_wdata", sram_if.wdata, 32'h0);
      chk("rst_sram_wstrb", sram_if.wstrb, 4'h0);
      chk("rst_sram_req", sram_if.req, 0);
      resetn = 1'b1;
      cyc();

      // single read with minimum latency
      t = mk(1, 0, 2'd2, 4'hf, 32'h1c00_0010, 32'h0);
      sb.push_back(t);
      drive(1, 1, t);
      wait_grant(1);
      g = last_g;
      data_if.req = 1'b0;
      wait_done();
      chk("lat_sram_req", first_req_cyc, g + 1);
      chk("lat_data_ok", last_mdok, g + 2);

      // simultaneous requests, data first
      t = mk(1, 0, 2'd2, 4'hf, 32'h0000_4000, 32'h0);
      sb.push_back(t);
      drive(1, 1, t);
      t = mk(0, 0, 2'd2, 4'hf, 32'h1c00_0100, 32'h0);
      sb.push_back(t);
      drive(0, 1, t);
      wait_grant(1);
      data_if.req = 1'b0;
      wait_grant(0);
      inst_if.req = 1'b0;
      chk("inst_after_data", last_g, last_mdok + 1);
      wait_done();

      // slave stall with master inputs changing
      stall_left = 5;
      t = mk(1, 1, 2'd2, 4'hc, 32'h0000_8008, 32'hCAFE_0001);
      sb.push_back(t);
      drive(1, 1, t);
      wait_grant(1);
      data_if.req   = 1'b0;
      data_if.addr  = 32'hFFFF_0000;
      data_if.wdata = 32'h5555_5555;
      data_if.wstrb = 4'h1;
      req_cnt = 0;
      wait_done();
      chk("stall_req_cycles", req_cnt, 6);

      // store passes size, strobes and data untouched
      dok_cnt_d = 0;
      t = mk(1, 1, 2'd1, 4'b0011, 32'h0000_0102, 32'h1234_5678);
      sb.push_back(t);
      drive(1, 1, t);
      wait_grant(1);
      data_if.req = 1'b0;
      wait_done();
      cyc();
      cyc();
      chk("store_dok_pulses", dok_cnt_d, 1);

      // reset while waiting in DATA
      dok_cfg = 3;
      t = mk(0, 0, 2'd2, 4'hf, 32'h1c00_0200, 32'h0);
      sb.push_back(t);
      drive(0, 1, t);
      wait_grant(0);
      inst_if.req = 1'b0;
      cyc();
      cyc();
      chk("in_data_phase", sl_data, 1);
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      dok_cfg = 0;
      stray = 1;
      cyc();
      cyc();
      stray = 0;
      chk("post_rst_addr", sram_if.addr, 32'h0);
      cyc();

      // back-to-back held request
      gi_cyc.delete();
      t = mk(0, 0, 2'd2, 4'hf, 32'h1c00_0300, 32'h0);
      for (int i = 0; i < 4; i++) sb.push_back(t);
      g0 = g_inst;
      drive(0, 1, t);
      for (int i = 0; i < 40 && g_inst < g0 + 4; i++) cyc();
      inst_if.req = 1'b0;
      chk("b2b_grants", g_inst - g0, 4);
      for (int i = 1; i < gi_cyc.size(); i++) begin
         chk("b2b_gap", gi_cyc[i] - gi_cyc[i-1], 3);
      end
      wait_done();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
